// File: rtl/cadd_pipe_if.sv
// Operand/result handshake bundle for cadd_pipe: operand beat in, result beat out, saturation counter.
interface cadd_pipe_if #(
  parameter int unsigned IN_W  = 8,
  parameter bit          SAT   = 1'b1,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned OUT_W = SAT ? IN_W : IN_W + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              op;
  logic signed [IN_W-1:0]  ar;
  logic signed [IN_W-1:0]  ai;
  logic signed [IN_W-1:0]  br;
  logic signed [IN_W-1:0]  bi;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] pr;
  logic signed [OUT_W-1:0] pi;
  logic                    sat;
  logic [CNT_W-1:0]        sat_cnt;
  logic                    cnt_clr;

  modport master (
    output in_valid, op, ar, ai, br, bi, out_ready, cnt_clr,
    input  in_ready, out_valid, pr, pi, sat, sat_cnt
  );

  modport slave (
    input  in_valid, op, ar, ai, br, bi, out_ready, cnt_clr,
    output in_ready, out_valid, pr, pi, sat, sat_cnt
  );
endinterface

// File: rtl/cadd_pipe.sv
// Two-stage complex add/subtract (optionally multiply-by-j on b) with saturation and
// a saturating count of delivered clipped results. Valid/ready on both sides.
module cadd_pipe #(
  parameter int unsigned IN_W  = 8,
  parameter bit          SAT   = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  cadd_pipe_if.slave  bus
);
  localparam int unsigned OUT_W = SAT ? IN_W : IN_W + 1;
  localparam int unsigned SUM_W = IN_W + 1;

  logic signed [SUM_W-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [SUM_W-1:0] w_sr, w_si;
  logic                    w_s2_load;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_deliver;
  logic signed [OUT_W-1:0] w_fr, w_fi;
  logic                    w_fsat;

  logic                    r_s1_v;
  logic signed [SUM_W-1:0] r_s1_r, r_s1_i;
  logic                    r_s2_v;
  logic signed [OUT_W-1:0] r_pr, r_pi;
  logic                    r_sat;
  logic [CNT_W-1:0]        r_cnt;

  assign w_ar = {bus.ar[IN_W-1], bus.ar};
  assign w_ai = {bus.ai[IN_W-1], bus.ai};
  assign w_br = {bus.br[IN_W-1], bus.br};
  assign w_bi = {bus.bi[IN_W-1], bus.bi};

  // op[1] rotates b by +j (10) or -j (11) before the add
  always_comb begin
    w_sr = '0;
    w_si = '0;
    unique case (bus.op)
      2'b00:   begin w_sr = w_ar + w_br; w_si = w_ai + w_bi; end
      2'b01:   begin w_sr = w_ar - w_br; w_si = w_ai - w_bi; end
      2'b10:   begin w_sr = w_ar - w_bi; w_si = w_ai + w_br; end
      default: begin w_sr = w_ar + w_bi; w_si = w_ai - w_br; end
    endcase
  end

  assign w_s2_load  = !r_s2_v || bus.out_ready;
  assign w_in_ready = !r_s1_v || w_s2_load;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_deliver  = r_s2_v && bus.out_ready;

  generate
    if (SAT) begin : g_sat
      localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
      localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
      logic w_ovf_r, w_ovf_i;
      // The IN_W+1 sum overflows IN_W exactly when its top two bits disagree
      assign w_ovf_r = r_s1_r[SUM_W-1] ^ r_s1_r[SUM_W-2];
      assign w_ovf_i = r_s1_i[SUM_W-1] ^ r_s1_i[SUM_W-2];
      assign w_fr    = w_ovf_r ? (r_s1_r[SUM_W-1] ? MIN_V : MAX_V) : r_s1_r[OUT_W-1:0];
      assign w_fi    = w_ovf_i ? (r_s1_i[SUM_W-1] ? MIN_V : MAX_V) : r_s1_i[OUT_W-1:0];
      assign w_fsat  = w_ovf_r | w_ovf_i;
    end else begin : g_full
      assign w_fr   = r_s1_r;
      assign w_fi   = r_s1_i;
      assign w_fsat = 1'b0;
    end
  endgenerate

  // S1: raw sums, loaded whenever a beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1_r <= '0;
      r_s1_i <= '0;
    end else if (w_in_ready) begin
      r_s1_v <= bus.in_valid;
      if (w_accept) begin
        r_s1_r <= w_sr;
        r_s1_i <= w_si;
      end
    end
  end

  // S2: final result; data only changes when S1 hands over a beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_pr   <= '0;
      r_pi   <= '0;
      r_sat  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_pr  <= w_fr;
        r_pi  <= w_fi;
        r_sat <= w_fsat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_deliver && r_sat && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_v;
  assign bus.pr        = r_pr;
  assign bus.pi        = r_pi;
  assign bus.sat       = r_sat;
  assign bus.sat_cnt   = r_cnt;
endmodule

// File: doc/cadd_pipe.md
CADD_PIPE -- requirements
Module: cadd_pipe

Interface
REQ-001 Parameters (name, default, meaning): one per line.
- IN_W, 8, operand component width, two's complement; default matches S3.4 TOTAL_WIDTH.
- SAT, 1, 1 = saturate result to IN_W; 0 = full-precision result of IN_W+1.
- CNT_W, 16, width of saturation event counter.
- OUT_W, derived: IN_W when SAT=1, else IN_W+1; not user-overridable.

REQ-002 Ports (name, direction, width, meaning): one per line, clock and reset first.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept operand beat.
- op  in  2  00 a+b, 01 a-b, 10 a+j*b, 11 a-j*b.
- ar, ai, br, bi  in  IN_W each  signed operand components.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- pr, pi  out  OUT_W each  signed result components.
- sat  out  1  either component of this result was clipped.
- sat_cnt  out  CNT_W  count of delivered saturated results.
- cnt_clr  in  1  synchronous clear of sat_cnt.

Function
REQ-003 Beat accepted at in_valid && in_ready; delivered at out_valid && out_ready.
REQ-004 Two register stages: S1 registers op-selected IN_W+1 sums; S2 registers saturated/final result and sat flag.
REQ-005 Latency 2 cycles from acceptance to out_valid with out_ready held high; throughput 1 beat/cycle.
REQ-006 Op arithmetic, computed sign-extended to IN_W+1, no truncation before S2:
- 00: pr=ar+br, pi=ai+bi.
- 01: pr=ar-br, pi=ai-bi.
- 10: pr=ar-bi, pi=ai+br.
- 11: pr=ar+bi, pi=ai-br.
REQ-007 SAT=1: each component clamps to [-2^(IN_W-1), 2^(IN_W-1)-1]; sat=1 if either clamped, else 0.
REQ-008 SAT=0: pr/pi are exact IN_W+1 values; sat tied 0.
REQ-009 Fixed-point position is preserved: no shift applied; binary point of result equals that of operands.
REQ-010 Stage advance rule: S2 loads when S2 empty or out_ready; S1 loads when S1 empty or S1 moving into S2.
REQ-011 in_ready = S1 empty or S1 advancing this cycle; combinational from out_ready permitted, no combinational path from in_valid.
REQ-012 With out_ready low, S2 and pr/pi/sat hold stable; at most 2 beats buffered; no beat dropped or duplicated; order preserved.
REQ-013 sat_cnt increments by 1 on each delivery with sat=1; saturates at all-ones (no wrap).
REQ-014 cnt_clr and increment in same cycle: cnt_clr wins, sat_cnt=0.
REQ-015 op and operands sampled only at acceptance; changes while in_ready=0 have no effect.

Reset
REQ-016 rst_n low asynchronously clears S1/S2 valid, pr=0, pi=0, sat=0, sat_cnt=0, out_valid=0.
REQ-017 in_ready=1 from the first edge after rst_n deasserts.
REQ-018 Reset mid-operation discards all buffered beats; no output after release until new beats accepted.
REQ-019 rst_n deassertion is synchronous to clk externally; no internal synchroniser.

Verification (IN_W=8, SAT=1, out_ready=1 unless stated)
REQ-020 op=00, (24,36)+(16,-8) accepted cycle 0 -> cycle 2 out_valid, pr=40, pi=28, sat=0.
REQ-021 Back-to-back beats: op=01 then op=10 with the same operands -> (8,44) then (32,52) on consecutive cycles.
REQ-022 op=00, ar=br=100 and ai=bi=-100 -> pr=127, pi=-128, sat=1, sat_cnt=1 after delivery.
REQ-023 out_ready=0, three beats offered -> two accepted, in_ready low on third. Raise out_ready -> all three delivered in order, outputs stable while stalled.
REQ-024 sat_cnt=5 and cnt_clr asserted in the cycle a saturated result is delivered -> sat_cnt=0.
REQ-025 rst_n pulsed low with 2 beats buffered -> outputs zero immediately; no stale result after release; new beat yields correct result at latency 2.
